// File: rtl/alu_types.sv
// alu_types: ALU operation encoding shared by the datapath and its controllers
package alu_types;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_control_t;

endpackage

// File: rtl/rv_mc_pkg.sv
// rv_mc_pkg: states, datapath mux encodings and error causes of the multicycle controller
package rv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_JAL, S_JALR, S_LINK, S_BRANCH, S_ERROR
    } state_t;

    typedef enum logic [1:0] {SRC_A_PC, SRC_A_OLD, SRC_A_RA} alu_src_a_t;
    typedef enum logic [1:0] {SRC_B_4, SRC_B_IMM, SRC_B_RB} alu_src_b_t;
    typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_LAST} result_src_t;
    typedef enum logic [1:0] {ERR_NONE, ERR_ILLEGAL, ERR_TIMEOUT, ERR_BRANCH} err_cause_t;

    // How the ALU operation is chosen: forced add, forced subtract, or from funct fields
    typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // funct3[0] inverts the base condition; funct3[2:1] picks zero, lt or ltu
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero, input logic lt,
                                          input logic ltu);
        return f3[0] ^ (f3[2] ? (f3[1] ? ltu : lt) : zero);
    endfunction

endpackage

// File: rtl/rv_alu_decoder.sv
// rv_alu_decoder: maps op/funct3/funct7_5 and the requested mode to an ALU operation
module rv_alu_decoder
    import alu_types::*;
    import rv_mc_pkg::*;
(
    input  alu_op_t      alu_op,
    input  logic [6:0]   op,
    input  logic [2:0]   funct3,
    input  logic         funct7_5,
    output alu_control_t alu_control
);

    // Subtract only exists for R-type; immediates reuse funct7_5 bit as part of imm
    always_comb begin
        alu_control = ALU_ADD;
        if (alu_op == ALUOP_SUB)
            alu_control = ALU_SUB;
        else if (alu_op == ALUOP_FUNCT)
            case (funct3)
                3'b000:  alu_control = (op == OP_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_control = ALU_SLL;
                3'b010:  alu_control = ALU_SLT;
                3'b011:  alu_control = ALU_SLTU;
                3'b100:  alu_control = ALU_XOR;
                3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
                3'b110:  alu_control = ALU_OR;
                default: alu_control = ALU_AND;
            endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: RV32I multicycle control FSM with memory timeout and retire counter
module rv_multicycle_ctrl
    import alu_types::*;
    import rv_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter bit BRANCH_FULL = 1,
    parameter int RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [6:0]          op,
    input  logic [2:0]          funct3,
    input  logic                funct7_5,
    input  logic                mem_ready,
    input  logic                zero,
    input  logic                lt,
    input  logic                ltu,
    output logic                mem_req,
    output logic                mem_wr_ena,
    output logic                adr_src,
    output logic                ir_ena,
    output logic                pc_ena,
    output logic                mdr_ena,
    output logic                reg_write,
    output alu_src_a_t          alu_src_a,
    output alu_src_b_t          alu_src_b,
    output alu_control_t        alu_control,
    output result_src_t         result_src,
    output logic                error,
    output err_cause_t          err_cause,
    output logic [RETIRE_W-1:0] instret
);

    localparam int WCW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;

    state_t         state, state_nxt;
    err_cause_t     cause_nxt;
    logic [WCW-1:0] wait_cnt;
    logic           mem_wait, timeout, br_legal;
    logic           req, wr, irw, pcw, mdrw, rw;
    alu_op_t        alu_op;

    assign mem_wait = (state == S_FETCH || state == S_MEMREAD || state == S_MEMWRITE) && !mem_ready;
    assign timeout  = (MEM_TIMEOUT != 0) && (wait_cnt == WCW'(MEM_TIMEOUT - 1));
    assign br_legal = (funct3[2:1] == 2'b00) || (BRANCH_FULL && funct3[2]);

    // State and latched error cause; everything freezes while ena is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_FETCH;
            err_cause <= ERR_NONE;
        end else if (ena) begin
            state     <= state_nxt;
            err_cause <= cause_nxt;
        end
    end

    // Wait counter restarts on every state change; retire counts each return to FETCH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            instret  <= '0;
        end else if (ena) begin
            wait_cnt <= (state_nxt != state) ? '0 : wait_cnt + WCW'(mem_wait);
            instret  <= instret + RETIRE_W'(state != S_FETCH && state_nxt == S_FETCH);
        end
    end

    // Next state; a completing memory access always beats the timeout
    always_comb begin
        state_nxt = state;
        cause_nxt = err_cause;
        case (state)
            S_FETCH, S_MEMREAD, S_MEMWRITE: begin
                if (mem_ready)
                    state_nxt = (state == S_FETCH) ? S_DECODE : (state == S_MEMREAD) ? S_MEMWB : S_FETCH;
                else if (timeout) begin
                    state_nxt = S_ERROR;
                    cause_nxt = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_nxt = (funct3 == 3'b010) ? S_MEMADR : S_ERROR;
                    OP_RTYPE:          state_nxt = S_EXECR;
                    OP_ITYPE:          state_nxt = S_EXECI;
                    OP_JAL:            state_nxt = S_JAL;
                    OP_JALR:           state_nxt = S_JALR;
                    OP_BRANCH:         state_nxt = br_legal ? S_BRANCH : S_ERROR;
                    default:           state_nxt = S_ERROR;
                endcase
                if (state_nxt == S_ERROR)
                    cause_nxt = (op == OP_BRANCH) ? ERR_BRANCH : ERR_ILLEGAL;
            end
            S_MEMADR:                            state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_EXECR, S_EXECI:                    state_nxt = S_ALUWB;
            S_JAL, S_JALR:                       state_nxt = S_LINK;
            S_MEMWB, S_ALUWB, S_LINK, S_BRANCH:  state_nxt = S_FETCH;
            default:                             state_nxt = S_ERROR;
        endcase
    end

    // Datapath controls per state; enables are gated by ena afterwards
    always_comb begin
        req        = 1'b0;
        wr         = 1'b0;
        irw        = 1'b0;
        pcw        = 1'b0;
        mdrw       = 1'b0;
        rw         = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_4;
        result_src = RES_ALU;
        alu_op     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                req = 1'b1;
                irw = mem_ready;
                pcw = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLD;
                alu_src_b = SRC_B_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRC_A_RA;
                alu_src_b = SRC_B_IMM;
            end
            S_MEMREAD: begin
                req     = 1'b1;
                adr_src = 1'b1;
                mdrw    = mem_ready;
            end
            S_MEMWB: begin
                result_src = RES_MEM;
                rw         = 1'b1;
            end
            S_MEMWRITE: begin
                req     = 1'b1;
                wr      = 1'b1;
                adr_src = 1'b1;
            end
            S_EXECR, S_EXECI: begin
                alu_src_a = SRC_A_RA;
                alu_src_b = (state == S_EXECR) ? SRC_B_RB : SRC_B_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                result_src = RES_LAST;
                rw         = 1'b1;
            end
            S_JAL: begin
                result_src = RES_LAST;
                pcw        = 1'b1;
            end
            S_JALR: begin
                alu_src_a = SRC_A_RA;
                alu_src_b = SRC_B_IMM;
                pcw       = 1'b1;
            end
            S_LINK: begin
                alu_src_a = SRC_A_OLD;
                rw        = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = SRC_A_RA;
                alu_src_b  = SRC_B_RB;
                alu_op     = ALUOP_SUB;
                result_src = RES_LAST;
                pcw        = branch_taken(funct3, zero, lt, ltu);
            end
            default: ;
        endcase
    end

    assign mem_req    = req & ena;
    assign mem_wr_ena = wr & ena;
    assign ir_ena     = irw & ena;
    assign pc_ena     = pcw & ena;
    assign mdr_ena    = mdrw & ena;
    assign reg_write  = rw & ena;
    assign error      = (state == S_ERROR);

    rv_alu_decoder u_dec (
        .alu_op      (alu_op),
        .op          (op),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .alu_control (alu_control)
    );

endmodule
